// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if
//   Bundles the request/result signals of the multiply sequencer together
//   with the operand/opcode/result lines of the shared combinational ALU.
//
//   Signals:
//     start, flush     : request and abort from the pipeline
//     op_a, op_b       : multiplicand and multiplier, captured on accept
//     busy, done       : sequencer status (done is a one-cycle pulse)
//     product          : registered low word of op_a*op_b
//     alu_control      : ALU opcode driven by the sequencer
//     alu_a, alu_b     : ALU operands driven by the sequencer
//     alu_result       : ALU result, returned in the same cycle
//
//   Modports:
//     slave  : the sequencer side
//     master : the pipeline/ALU environment side
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  start, flush, op_a, op_b, alu_result,
    output busy, done, product, alu_control, alu_a, alu_b
  );

  modport master (
    output start, flush, op_a, op_b, alu_result,
    input  busy, done, product, alu_control, alu_a, alu_b
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Computes the low WIDTH bits of op_a*op_b by driving the shared
//   combinational ALU through alternating ADD and shift-left steps.
//   The result is the same for signed and unsigned operands.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : synchronous, active-low reset
//     bus    : alu_mul_sequencer_if.slave (start/flush/operands in,
//              busy/done/product out, ALU opcode/operands out,
//              ALU result in)
//
//   Optional build macro:
//     ALU_MUL_SEQ_EARLY_EXIT_EN : when defined, finish as soon as no
//     multiplier bits remain instead of always running WIDTH iterations.
module alu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_mul_sequencer_if.slave   bus
);

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SHIFT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] product;
  logic             last_iter;
  logic             busy;
  logic             done;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;

  // The SHIFT step is the final one either after WIDTH iterations or, with
  // early exit enabled, once the remaining multiplier bits are all zero.
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  // Next-state and ALU steering. The ALU is only driven while busy so the
  // execute stage sees a quiet mux otherwise. Flush overrides every
  // transition so an aborted operation never reaches DONE.
  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    done        = 1'b0;
    alu_control = OP_NONE;
    alu_a       = '0;
    alu_b       = '0;
    case (state)
      IDLE: begin
        if (bus.start) next_state = ADD;
      end
      ADD: begin
        busy        = 1'b1;
        alu_control = OP_ADD;
        alu_a       = acc;
        alu_b       = mplier[0] ? mcand : '0;
        next_state  = SHIFT;
      end
      SHIFT: begin
        busy        = 1'b1;
        alu_control = OP_SHIFT;
        alu_a       = mcand;
        alu_b       = WIDTH'(1);
        next_state  = last_iter ? DONE : ADD;
      end
      DONE: begin
        done       = 1'b1;
        next_state = bus.start ? ADD : IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (bus.flush) next_state = IDLE;
  end

  // State and datapath registers. Data updates are suppressed on flush so
  // an abort in the final SHIFT cannot disturb the held product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= next_state;
      if (!bus.flush) begin
        case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              mcand  <= bus.op_a;
              mplier <= bus.op_b;
              acc    <= '0;
              cnt    <= '0;
            end
          end
          ADD: begin
            acc <= bus.alu_result;
          end
          SHIFT: begin
            mcand  <= bus.alu_result;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) product <= acc;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.product     = product;
  assign bus.alu_control = alu_control;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
//   Self-checking bench for alu_mul_sequencer. Models the shared ALU
//   (ADD and shift-left) and compares results against plain 64-bit
//   multiplication truncated to the low word, plus the expected latency.
//   Honors ALU_MUL_SEQ_EARLY_EXIT_EN when computing expected latency.
module tb_alu_mul_sequencer;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational ALU shared with the sequencer.
  assign bus.alu_result = (bus.alu_control == 4'b0010) ? bus.alu_a + bus.alu_b :
                          (bus.alu_control == 4'b1111) ? bus.alu_a << bus.alu_b :
                          '0;

  // Reference product: low word of the full-width product.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b);
    return full[31:0];
  endfunction

  // Reference latency in cycles from the accepting edge to the done cycle.
  function automatic int exp_latency(input logic [31:0] b);
    int msb;
    msb = -1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) msb = i;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    if (msb < 0) return 3;
    return 2 * (msb + 1) + 1;
`else
    return 2 * WIDTH + 1 + (msb - msb);
`endif
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
  endtask

  // Steps the clock until done, bounded, collecting latency, busy cycles and
  // any opcode outside the allowed set. Optionally injects a one-cycle start.
  task automatic run_to_done(input int inject_at, input logic [31:0] ia, input logic [31:0] ib,
                             output int lat, output int busy_n, output int bad_ops,
                             output bit timed_out);
    lat = 0; busy_n = 0; bad_ops = 0; timed_out = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      lat++;
      bus.start = 1'b0;
      if (bus.busy) begin
        busy_n++;
        if (bus.alu_control != 4'b0010 && bus.alu_control != 4'b1111) bad_ops++;
      end else if (bus.alu_control != 4'b0000) begin
        bad_ops++;
      end
      if (bus.done) begin
        timed_out = 1'b0;
        break;
      end
      if (lat == inject_at) begin
        bus.start = 1'b1;
        bus.op_a  = ia;
        bus.op_b  = ib;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.flush = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.product !== 32'h0) begin errors++; $display("[TB] FAIL reset_product: got %h expected 0", bus.product); end
    checks++; if (bus.alu_control !== 4'b0000) begin errors++; $display("[TB] FAIL reset_alu_control: got %b expected 0000", bus.alu_control); end
    checks++; if (bus.alu_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_alu_a: got %h expected 0", bus.alu_a); end
    checks++; if (bus.alu_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_alu_b: got %h expected 0", bus.alu_b); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, busy_n, bad_ops; bit to;
    issue(32'd6, 32'd7);
    run_to_done(0, 0, 0, lat, busy_n, bad_ops, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
    checks++; if (lat != exp_latency(32'd7)) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, exp_latency(32'd7)); end
    checks++; if (bus.product !== 32'd42) begin errors++; $display("[TB] FAIL basic_product: got %0d expected 42", bus.product); end
    checks++; if (busy_n != exp_latency(32'd7) - 1) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", busy_n, exp_latency(32'd7) - 1); end
    checks++; if (bad_ops != 0) begin errors++; $display("[TB] FAIL basic_alu_ops: got %0d illegal expected 0", bad_ops); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", bus.done); end
    checks++; if (bus.product !== 32'd42) begin errors++; $display("[TB] FAIL basic_product_hold: got %0d expected 42", bus.product); end
  endtask

  task automatic test_corners();
    logic [31:0] ta [3] = '{32'hFFFFFFFF, 32'h80000000, 32'd9};
    logic [31:0] tb [3] = '{32'hFFFFFFFF, 32'd2, 32'd0};
    int lat, busy_n, bad_ops; bit to;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i]);
      run_to_done(0, 0, 0, lat, busy_n, bad_ops, to);
      checks++; if (to || lat != exp_latency(tb[i])) begin errors++; $display("[TB] FAIL corner_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(tb[i])); end
      checks++; if (bus.product !== ref_mul(ta[i], tb[i])) begin errors++; $display("[TB] FAIL corner_product[%0d]: got %h expected %h", i, bus.product, ref_mul(ta[i], tb[i])); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int lat, busy_n, bad_ops, gap; bit to;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      issue(a, b);
      run_to_done(0, 0, 0, lat, busy_n, bad_ops, to);
      checks++; if (to || lat != exp_latency(b)) begin errors++; $display("[TB] FAIL random_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(b)); end
      checks++; if (bus.product !== ref_mul(a, b)) begin errors++; $display("[TB] FAIL random_product[%0d]: got %h expected %h", i, bus.product, ref_mul(a, b)); end
      checks++; if (bad_ops != 0) begin errors++; $display("[TB] FAIL random_alu_ops[%0d]: got %0d illegal expected 0", i, bad_ops); end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_flush();
    int lat, busy_n, bad_ops, seen; bit to;
    issue(32'd3, 32'd5);
    run_to_done(0, 0, 0, lat, busy_n, bad_ops, to);
    checks++; if (to || bus.product !== 32'd15) begin errors++; $display("[TB] FAIL flush_setup: got %0d expected 15", bus.product); end
    @(posedge clk); #1;
    issue(32'd6, 32'd7);
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; bus.start = 1'b0; end
    bus.flush = 1'b1; bus.start = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd2;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL flush_done: got %b expected 0", bus.done); end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL flush_no_activity: got %0d active cycles expected 0", seen); end
    checks++; if (bus.product !== 32'd15) begin errors++; $display("[TB] FAIL flush_product: got %0d expected 15", bus.product); end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n, bad_ops; bit to;
    issue(32'd6, 32'd7);
    run_to_done(10, 32'd3, 32'd3, lat, busy_n, bad_ops, to);
    checks++; if (to || lat != exp_latency(32'd7)) begin errors++; $display("[TB] FAIL ignore_start_latency: got %0d expected %0d", lat, exp_latency(32'd7)); end
    checks++; if (bus.product !== 32'd42) begin errors++; $display("[TB] FAIL ignore_start_product: got %0d expected 42", bus.product); end
    issue(32'd3, 32'd3);
    run_to_done(0, 0, 0, lat, busy_n, bad_ops, to);
    checks++; if (to || lat != exp_latency(32'd3)) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, exp_latency(32'd3)); end
    checks++; if (bus.product !== 32'd9) begin errors++; $display("[TB] FAIL b2b_product: got %0d expected 9", bus.product); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, busy_n, bad_ops; bit to;
    issue(32'd9, 32'd11);
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; bus.start = 1'b0; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_status: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    checks++; if (bus.product !== 32'h0) begin errors++; $display("[TB] FAIL midreset_product: got %h expected 0", bus.product); end
    checks++; if (bus.alu_control !== 4'b0000 || bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin errors++; $display("[TB] FAIL midreset_alu: got %b %h %h expected 0000 0 0", bus.alu_control, bus.alu_a, bus.alu_b); end
    issue(32'd5, 32'd5);
    run_to_done(0, 0, 0, lat, busy_n, bad_ops, to);
    checks++; if (to || lat != exp_latency(32'd5)) begin errors++; $display("[TB] FAIL midreset_latency: got %0d expected %0d", lat, exp_latency(32'd5)); end
    checks++; if (bus.product !== 32'd25) begin errors++; $display("[TB] FAIL midreset_product_after: got %0d expected 25", bus.product); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes 32-bit multiply (low word of a*b) by sequencing the shared combinational ALU with shift-add iterations.
- Sits beside the ALU in the execute stage and owns the ALU input mux while busy.
- Uses only existing ALU opcodes: ADD (4'b0010) and shift-left (4'b1111); no dedicated multiplier hardware.
- Result is identical for signed and unsigned operands (low word only).

Parameters:
- WIDTH, 32, operand/result width; must match ALU width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only in IDLE or DONE
- flush  input  1  abort current operation (pipeline flush)
- op_a  input  WIDTH  multiplicand, captured when start accepted
- op_b  input  WIDTH  multiplier, captured when start accepted
- busy  output  1  high in ADD and SHIFT states
- done  output  1  one-cycle pulse, product valid
- product  output  WIDTH  registered result, held until next completion
- alu_control  output  4  ALU opcode
- alu_a  output  WIDTH  ALU operand a
- alu_b  output  WIDTH  ALU operand b
- alu_result  input  WIDTH  ALU result, same cycle (combinational ALU)

Interface: one clock, clk; reset rst_n is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-operation:
  - State goes to IDLE; acc, mcand, mplier, cnt cleared; product=0.
  - busy=0, done=0; alu_control=4'b0000, alu_a=0, alu_b=0.
- States: IDLE, ADD, SHIFT, DONE (registered). ALU outputs are combinational from state and internal registers.
- IDLE: ALU outputs 0/0/0.
  - start=1 and flush=0: mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0, go to ADD.
- ADD: alu_control=4'b0010, alu_a=acc, alu_b=(mplier[0] ? mcand : 0).
  - acc<=alu_result; go to SHIFT. ADD always executes, giving fixed latency.
- SHIFT: alu_control=4'b1111, alu_a=mcand, alu_b=1.
  - mcand<=alu_result; mplier<=mplier>>1 (internal shift); cnt<=cnt+1.
  - If cnt==WIDTH-1, go to DONE; else go to ADD.
- DONE: product<=acc at entry; done=1 for exactly this cycle; busy=0.
  - start=1 and flush=0: accept new operands, go to ADD (back-to-back).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0; ADD/SHIFT occupy 2*WIDTH cycles; done is high in cycle 2*WIDTH+1 after E0 (65 for WIDTH=32).
- Arithmetic: all sums are modulo 2^WIDTH; overflow bits are discarded silently; mcand shifts out its MSB.
- start while busy: ignored; no queuing.
- flush=1 in any state: go to IDLE next edge. No done pulse, product unchanged. flush wins over a simultaneous start.
- rst_n=0 wins over flush and start.

Optional Feature:
- Macro: ALU_MUL_SEQ_EARLY_EXIT_EN
- Defined: in SHIFT, if (mplier>>1)==0, go to DONE regardless of cnt. Latency = 2*(index of highest set bit of op_b + 1)+1. op_b=0 still runs one ADD/SHIFT pair (latency 3).
- Undefined: fixed latency 2*WIDTH+1 for all operands.

Test Plan:
- Reset, then op_a=6, op_b=7, start pulse -> done high exactly 65 cycles later, product=42, busy high for 64 cycles; ALU sees only 4'b0010/4'b1111.
- op_a=32'hFFFFFFFF, op_b=32'hFFFFFFFF -> product=32'h00000001. Then op_a=32'h80000000, op_b=2 -> product=0 (wrap).
- Start 6*7, assert flush at cycle 20 -> no done pulse, busy=0 next cycle, product keeps previous value. A start issued in the same cycle as flush is not accepted.
- During 6*7, pulse start with op_a=3, op_b=3 at cycle 10 -> ignored, product=42. Then start 3*3 in the DONE cycle -> second done 65 cycles later, product=9.
- rst_n=0 for one edge at cycle 30 of an operation -> all outputs at reset values next cycle; a new 5*5 then completes normally with product=25.
- With ALU_MUL_SEQ_EARLY_EXIT_EN defined: 6*7 -> done at cycle 7, product=42. 9*0 -> done at cycle 3, product=0.
